// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control decoder.
// Imported by the main FSM and the decoder top.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECR,
    EXECI,
    ALUWB,
    BRANCH
  } statetype_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

endpackage

// File: rtl/mc_decoder_mainfsm.sv
// Moore main FSM: sequences fetch, decode and execute cycles
// and drives datapath selects and raw write requests.
module mainfsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] op_i,
  input  logic [5:0] funct_i,
  output logic       ir_write_o,
  output logic       next_pc_o,
  output logic       adr_src_o,
  output logic [1:0] result_src_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic       reg_w_o,
  output logic       mem_w_o,
  output logic       alu_op_o,
  output logic       branch_o
);

  statetype_t state_q, state_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= FETCH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = FETCH;
    ir_write_o   = 1'b0;
    next_pc_o    = 1'b0;
    adr_src_o    = 1'b0;
    result_src_o = RES_ALUOUT;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SRCB_REG;
    reg_w_o      = 1'b0;
    mem_w_o      = 1'b0;
    alu_op_o     = 1'b0;
    branch_o     = 1'b0;
    case (state_q)
      FETCH: begin
        state_d      = DECODE;
        ir_write_o   = 1'b1;
        next_pc_o    = 1'b1;
        alu_src_a_o  = 1'b1;
        alu_src_b_o  = SRCB_FOUR;
        result_src_o = RES_ALURES;
      end
      DECODE: begin
        alu_src_a_o  = 1'b1;
        alu_src_b_o  = SRCB_FOUR;
        result_src_o = RES_ALURES;
        case (op_i)
          OP_MEM:  state_d = MEMADR;
          OP_DP:   state_d = funct_i[5] ? EXECI : EXECR;
          OP_BR:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: begin
        state_d     = funct_i[0] ? MEMRD : MEMWR;
        alu_src_b_o = SRCB_IMM;
      end
      MEMRD: begin
        state_d   = MEMWB;
        adr_src_o = 1'b1;
      end
      MEMWB: begin
        result_src_o = RES_DATA;
        reg_w_o      = 1'b1;
      end
      MEMWR: begin
        adr_src_o = 1'b1;
        mem_w_o   = 1'b1;
      end
      EXECR: begin
        state_d  = ALUWB;
        alu_op_o = 1'b1;
      end
      EXECI: begin
        state_d     = ALUWB;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = 1'b1;
      end
      ALUWB: reg_w_o = 1'b1;
      BRANCH: begin
        alu_src_b_o  = SRCB_IMM;
        result_src_o = RES_ALURES;
        branch_o     = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: rtl/mc_decoder.sv
// Multicycle ARM control decoder: main FSM plus ALU decode,
// PC-write request and immediate/register source selects.
module mc_decoder
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc
);

  logic alu_op;
  logic branch;

  mainfsm u_fsm (
    .clk_i       (clk),
    .reset_i     (reset),
    .op_i        (Op),
    .funct_i     (Funct),
    .ir_write_o  (IRWrite),
    .next_pc_o   (NextPC),
    .adr_src_o   (AdrSrc),
    .result_src_o(ResultSrc),
    .alu_src_a_o (ALUSrcA),
    .alu_src_b_o (ALUSrcB),
    .reg_w_o     (RegW),
    .mem_w_o     (MemW),
    .alu_op_o    (alu_op),
    .branch_o    (branch)
  );

  // Only ADD/SUB produce meaningful carry/overflow, so CV is gated on them
  always_comb begin
    ALUControl = ALU_ADD;
    FlagW      = 2'b00;
    if (alu_op) begin
      unique case (Funct[4:1])
        4'b0100: ALUControl = ALU_ADD;
        4'b0010: ALUControl = ALU_SUB;
        4'b0000: ALUControl = ALU_AND;
        4'b1100: ALUControl = ALU_ORR;
        default: ALUControl = ALU_ADD;
      endcase
      FlagW[1] = Funct[0];
      FlagW[0] = Funct[0] & ~ALUControl[1];
    end
  end

  assign PCS    = branch | (RegW & (Rd == 4'b1111));
  assign ImmSrc = Op;
  assign RegSrc = {Op == OP_MEM, Op == OP_BR};

endmodule

// File: tb/tb_mc_decoder.sv
// Randomized self-checking bench for mc_decoder against a
// per-instruction-class cycle table model.
module tb_mc_decoder;

  typedef struct packed {
    logic [1:0] flagw;
    logic       pcs;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       irwrite;
    logic       adrsrc;
    logic [1:0] resultsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluctl;
    logic [1:0] immsrc;
    logic [1:0] regsrc;
  } ov_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [1:0] FlagW, ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic       PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ALUSrcA;

  int checks = 0;
  int errors = 0;
  int m_step = 0;
  ov_t obs [8];

  mc_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .Funct     (Funct),
    .Rd        (Rd),
    .FlagW     (FlagW),
    .PCS       (PCS),
    .NextPC    (NextPC),
    .RegW      (RegW),
    .MemW      (MemW),
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUControl(ALUControl),
    .ImmSrc    (ImmSrc),
    .RegSrc    (RegSrc)
  );

  always #5 clk = ~clk;

  function automatic ov_t dut_out();
    ov_t o;
    o = '{FlagW, PCS, NextPC, RegW, MemW, IRWrite, AdrSrc,
          ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc};
    return o;
  endfunction

  function automatic int ilen(input logic [1:0] op,
                              input logic [5:0] f);
    case (op)
      2'b01:   return f[0] ? 5 : 4;
      2'b00:   return 4;
      2'b10:   return 3;
      default: return 2;
    endcase
  endfunction

  // Expected outputs for cycle s of an instruction (s=0 is fetch)
  function automatic ov_t model(input logic [1:0] op,
                                input logic [5:0] f,
                                input logic [3:0] rd,
                                input int s);
    ov_t o;
    o = '0;
    o.immsrc = op;
    o.regsrc = {op == 2'b01, op == 2'b10};
    if (s == 0) begin
      o.alusrca = 1; o.alusrcb = 2; o.resultsrc = 2;
      o.irwrite = 1; o.nextpc = 1;
    end else if (s == 1) begin
      o.alusrca = 1; o.alusrcb = 2; o.resultsrc = 2;
    end else if (op == 2'b01) begin
      if (s == 2) o.alusrcb = 1;
      else if (s == 3) begin
        o.adrsrc = 1;
        o.memw = !f[0];
      end else begin
        o.resultsrc = 1; o.regw = 1;
      end
    end else if (op == 2'b00) begin
      if (s == 2) begin
        o.alusrcb = f[5] ? 2'd1 : 2'd0;
        case (f[4:1])
          4'b0010: o.aluctl = 1;
          4'b0000: o.aluctl = 2;
          4'b1100: o.aluctl = 3;
          default: o.aluctl = 0;
        endcase
        o.flagw = {f[0], f[0] && o.aluctl < 2};
      end else o.regw = 1;
    end else if (op == 2'b10) begin
      o.alusrcb = 1; o.resultsrc = 2; o.pcs = 1;
    end
    if (o.regw && rd == 4'hf) o.pcs = 1;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    ov_t e, g;
    g = dut_out();
    e = reset ? model(2'b11, 6'd0, 4'd0, 0) : model(Op, Funct, Rd, m_step);
    e.immsrc = Op;
    e.regsrc = {Op == 2'b01, Op == 2'b10};
    obs[m_step] = g;
    chk($sformatf("cycle op=%0d f=%0h rd=%0d step=%0d",
                  Op, Funct, Rd, m_step), 32'(g), 32'(e));
  end

  task automatic run_instr(input logic [1:0] op,
                           input logic [5:0] f,
                           input logic [3:0] rd);
    for (int i = 0; i < 8; i++) obs[i] = '0;
    Op = op; Funct = f; Rd = rd;
    for (int s = 0; s < ilen(op, f); s++) begin
      m_step = s;
      @(posedge clk);
      #1;
    end
    m_step = 0;
  endtask

  initial begin
    int nreg;
    ov_t g;
    reset = 1'b1; Op = 2'b00; Funct = 6'd0; Rd = 4'd0;
    #1;
    g = dut_out();
    chk("reset_irwrite", g.irwrite, 1);
    chk("reset_nextpc", g.nextpc, 1);
    chk("reset_srcs", {g.alusrca, g.alusrcb, g.resultsrc}, 5'b11010);
    chk("reset_writes", {g.adrsrc, g.regw, g.memw, g.pcs, g.flagw,
                         g.aluctl}, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    run_instr(2'b01, 6'b011001, 4'd3);
    chk("ldr_regw_c5", obs[4].regw, 1);
    chk("ldr_res_c5", obs[4].resultsrc, 2'b01);
    nreg = 0;
    for (int i = 0; i < 5; i++) nreg += int'(obs[i].regw);
    chk("ldr_regw_once", nreg, 1);
    chk("ldr_memw_c4", obs[3].memw, 0);

    run_instr(2'b01, 6'b011000, 4'd3);
    chk("str_memw_c4", {obs[3].memw, obs[3].adrsrc}, 2'b11);
    chk("str_regw", obs[3].regw | obs[2].regw, 0);

    run_instr(2'b00, 6'b001001, 4'd2);
    chk("adds_ctl", obs[2].aluctl, 2'b00);
    chk("adds_flagw", obs[2].flagw, 2'b11);
    chk("adds_regw", obs[3].regw, 1);
    run_instr(2'b00, 6'b000100, 4'd2);
    chk("sub_ctl", obs[2].aluctl, 2'b01);
    chk("sub_flagw", obs[2].flagw, 2'b00);
    run_instr(2'b00, 6'b011001, 4'd2);
    chk("orrs_ctl", obs[2].aluctl, 2'b11);
    chk("orrs_flagw", obs[2].flagw, 2'b10);

    run_instr(2'b10, 6'b100000, 4'd0);
    chk("b_pcs", obs[2].pcs, 1);
    chk("b_srcb", obs[2].alusrcb, 2'b01);
    run_instr(2'b11, 6'b000000, 4'd0);
    chk("nop_writes", {obs[1].regw, obs[1].memw, obs[1].pcs}, 0);

    run_instr(2'b00, 6'b101000, 4'd15);
    chk("dp_r15_pcs", {obs[3].pcs, obs[3].regw}, 2'b11);
    run_instr(2'b00, 6'b101000, 4'd14);
    chk("dp_r14_pcs", obs[3].pcs, 0);

    // Abandon a load while it sits in the memory-read cycle
    Op = 2'b01; Funct = 6'b011001; Rd = 4'd15;
    for (int s = 0; s < 3; s++) begin
      m_step = s;
      @(posedge clk);
      #1;
    end
    m_step = 3;
    @(negedge clk);
    #2;
    reset = 1'b1;
    m_step = 0;
    #1;
    g = dut_out();
    chk("midrst_fetch", {g.irwrite, g.adrsrc, g.regw, g.pcs}, 4'b1000);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int n = 0; n < 400; n++) begin
      run_instr(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
                4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
